// File: rtl/serial_rx_ram.sv
// Serial receiver that turns 16-bit UART-style frames into RAM write cycles.
// Valid frames are written at an auto-incrementing 8-bit address; bad stop bits pulse frame_err.
module serial_rx_ram #(
  parameter int BIT_TICKS = 16
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        serialIn,
  output logic        write,
  output logic [7:0]  addr,
  output logic [15:0] data_out,
  output logic        busy,
  output logic        frame_err
);

  localparam int TW = $clog2(BIT_TICKS);
  localparam logic [TW-1:0] HALF_END = TW'(BIT_TICKS / 2 - 1);
  localparam logic [TW-1:0] FULL_END = TW'(BIT_TICKS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t         state, state_n;
  logic           rx_q1, rx_s, rx_prev;
  logic [TW-1:0]  tick, tick_n;
  logic [3:0]     bit_cnt, bit_cnt_n;
  logic [15:0]    shift, shift_n, data_n;
  logic           write_n, ferr_n;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state     <= IDLE;
      rx_q1     <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev   <= 1'b1;
      tick      <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      write     <= 1'b0;
      frame_err <= 1'b0;
      addr      <= '0;
      data_out  <= '0;
    end else begin
      state     <= state_n;
      rx_q1     <= serialIn;
      rx_s      <= rx_q1;
      rx_prev   <= rx_s;
      tick      <= tick_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      write     <= write_n;
      frame_err <= ferr_n;
      data_out  <= data_n;
      // Address advances the cycle after the strobe so the RAM sees a stable addr during write.
      if (write) addr <= addr + 8'd1;
    end
  end

  always_comb begin
    state_n   = state;
    tick_n    = tick;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    data_n    = data_out;
    write_n   = 1'b0;
    ferr_n    = 1'b0;
    case (state)
      IDLE: begin
        if (rx_prev && !rx_s) begin
          state_n = START;
          tick_n  = '0;
        end
      end
      START: begin
        if (tick == HALF_END) begin
          tick_n    = '0;
          bit_cnt_n = '0;
          state_n   = rx_s ? IDLE : DATA;
        end else begin
          tick_n = tick + 1'b1;
        end
      end
      DATA: begin
        if (tick == FULL_END) begin
          tick_n           = '0;
          shift_n[bit_cnt] = rx_s;
          if (bit_cnt == 4'd15) begin
            bit_cnt_n = '0;
            state_n   = STOP;
          end else begin
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end else begin
          tick_n = tick + 1'b1;
        end
      end
      STOP: begin
        if (tick == FULL_END) begin
          tick_n = '0;
          if (rx_s) begin
            write_n = 1'b1;
            data_n  = shift;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = WAIT_IDLE;
          end
        end else begin
          tick_n = tick + 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_rx_ram.sv
// Scoreboard bench for serial_rx_ram: frames push expected writes/errors, a monitor pops and compares.
module tb_serial_rx_ram;

  localparam int BT = 16;

  logic        sysclk = 1'b0;
  logic        reset;
  logic        serialIn;
  logic        write;
  logic [7:0]  addr;
  logic [15:0] data_out;
  logic        busy;
  logic        frame_err;

  serial_rx_ram #(.BIT_TICKS(BT)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .serialIn  (serialIn),
    .write     (write),
    .addr      (addr),
    .data_out  (data_out),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    bit          is_err;
    logic [15:0] data;
    logic [7:0]  addr;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_addr = 0;
  logic [15:0] last_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Monitor: compares each write / frame_err pulse against the oldest expected entry.
  bit         addr_pend = 0;
  logic [7:0] addr_next;
  always @(negedge sysclk) begin
    if (reset) begin
      addr_pend = 0;
    end else begin
      if (addr_pend) begin
        check("addr_incr", {24'd0, addr}, {24'd0, addr_next});
        addr_pend = 0;
      end
      if (write && frame_err) check("write_ferr_excl", 32'd1, 32'd0);
      if (write || frame_err) begin
        if (sb_q.size() == 0) begin
          check(write ? "unexpected_write" : "unexpected_ferr", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("kind_is_err", {31'd0, frame_err}, {31'd0, e.is_err});
          check("data_out", {16'd0, data_out}, {16'd0, e.data});
          check("addr", {24'd0, addr}, {24'd0, e.addr});
          if (write) begin
            check("busy_in_write", {31'd0, busy}, 32'd0);
            addr_next = e.addr + 8'd1;
            addr_pend = 1;
          end
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic do_reset();
    @(negedge sysclk);
    reset    = 1'b1;
    serialIn = 1'b1;
    cycles(3);
    reset     = 1'b0;
    sb_q.delete();
    exp_addr  = 0;
    last_data = '0;
  endtask

  task automatic drive_bit(input logic b, input int n);
    serialIn = b;
    cycles(n);
  endtask

  task automatic send_frame(input logic [15:0] d, input bit good);
    exp_t e;
    if (good) begin
      e = '{is_err: 1'b0, data: d, addr: 8'(exp_addr)};
      exp_addr  = (exp_addr + 1) % 256;
      last_data = d;
    end else begin
      e = '{is_err: 1'b1, data: last_data, addr: 8'(exp_addr)};
    end
    sb_q.push_back(e);
    drive_bit(1'b0, BT);
    for (int unsigned i = 0; i < 16; i++) drive_bit(d[i], BT);
    drive_bit(good ? 1'b1 : 1'b0, BT);
    serialIn = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 64) begin
      cycles(1);
      n++;
    end
    check("drain_timeout", sb_q.size(), 32'd0);
    cycles(2);
  endtask

  initial begin
    logic [15:0] pat;
    reset    = 1'b1;
    serialIn = 1'b1;
    do_reset();

    check("rst_write", {31'd0, write}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_addr", {24'd0, addr}, 32'd0);
    check("rst_data", {16'd0, data_out}, 32'd0);

    // Single valid frame
    send_frame(16'hA5C3, 1'b1);
    drain();
    check("a5c3_addr_after", {24'd0, addr}, 32'd1);
    check("a5c3_data_hold", {16'd0, data_out}, 32'h0000A5C3);

    // Start-bit glitch
    do_reset();
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 3 * BT);
    check("glitch_busy", {31'd0, busy}, 32'd0);
    check("glitch_addr", {24'd0, addr}, 32'd0);

    // Bad stop bit keeps previous data and address
    send_frame(16'hBEEF, 1'b1);
    send_frame(16'h1234, 1'b0);
    cycles(2 * BT);
    drain();
    check("ferr_data_hold", {16'd0, data_out}, 32'h0000BEEF);
    check("ferr_addr_hold", {24'd0, addr}, 32'd1);
    check("ferr_busy_idle", {31'd0, busy}, 32'd0);
    send_frame(16'h0F0F, 1'b1);
    drain();

    // Back-to-back frames
    do_reset();
    send_frame(16'h0001, 1'b1);
    send_frame(16'h8000, 1'b1);
    drain();
    check("b2b_addr", {24'd0, addr}, 32'd2);

    // Reset at data bit 8 abandons the frame
    pat = 16'h5555;
    drive_bit(1'b0, BT);
    for (int unsigned i = 0; i < 8; i++) drive_bit(pat[i], BT);
    drive_bit(pat[8], BT / 2);
    do_reset();
    check("midrst_write", {31'd0, write}, 32'd0);
    check("midrst_ferr", {31'd0, frame_err}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_addr", {24'd0, addr}, 32'd0);
    check("midrst_data", {16'd0, data_out}, 32'd0);
    send_frame(16'hFFFF, 1'b1);
    drain();
    check("ffff_data", {16'd0, data_out}, 32'h0000FFFF);

    // 256 frames wrap the address
    do_reset();
    for (int unsigned i = 0; i < 256; i++) begin
      pat = 16'($urandom);
      send_frame(pat, 1'b1);
    end
    drain();
    check("wrap_addr", {24'd0, addr}, 32'd0);
    check("wrap_busy", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_rx_ram.md
SERIAL_RX_RAM -- requirements
Module: serial_rx_ram

Interface
REQ-001 SHALL have parameter BIT_TICKS, default 16: sysclk cycles per serial bit; even value, minimum 4.
REQ-002 SHALL have port sysclk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port serialIn, input, 1: asynchronous serial line, idle high.
REQ-005 SHALL have port write, output, 1: one-cycle RAM write strobe.
REQ-006 SHALL have port addr, output, 8: RAM write address.
REQ-007 SHALL have port data_out, output, 16: received word presented to RAM data_in.
REQ-008 SHALL have port busy, output, 1: high while a frame is in progress.
REQ-009 SHALL have port frame_err, output, 1: one-cycle pulse on a bad stop bit.

Function
REQ-010 SHALL accept frames of: 1 start bit (0), 16 data bits LSB first, 1 stop bit (1); each bit BIT_TICKS cycles.
REQ-011 SHALL pass serialIn through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-012 SHALL implement states IDLE, START, DATA, STOP, WAIT_IDLE with a tick counter and a 4-bit bit counter.
REQ-013 IDLE: on rx_s high-to-low transition, go to START and clear the tick counter; busy goes high the same cycle.
REQ-014 START: at tick BIT_TICKS/2-1, rx_s low -> DATA with counters cleared; rx_s high -> IDLE (glitch), no output change.
REQ-015 DATA: sample rx_s every BIT_TICKS cycles (mid-bit) into shift register bit position bit_cnt; after bit 15 sampled -> STOP.
REQ-016 STOP: at mid-bit sample, rx_s high -> next cycle write=1 with data_out = received word and addr = current address, then IDLE.
REQ-017 STOP: rx_s low -> next cycle frame_err=1 for one cycle, no write, addr unchanged, go to WAIT_IDLE.
REQ-018 WAIT_IDLE: remain until rx_s high, then IDLE; a new start is not detected until after that.
REQ-019 addr SHALL increment by 1 on the cycle after each write pulse; 8-bit wrap 0xFF -> 0x00, no overflow flag.
REQ-020 data_out SHALL hold the last valid received word until the next valid frame; not updated on frame_err.
REQ-021 busy SHALL be high in START, DATA, STOP, WAIT_IDLE and low in IDLE; low during the write cycle.
REQ-022 write and frame_err SHALL never assert in the same cycle and each lasts exactly one cycle.
REQ-023 Latency: write asserts 3 cycles after the stop-bit mid-point appears on serialIn (2 sync + 1 register).

Reset
REQ-024 reset SHALL force IDLE, counters 0, write=0, frame_err=0, busy=0, addr=0x00, data_out=0x0000, synchronizer flops=1.
REQ-025 reset asserted mid-frame SHALL abandon the frame with no write; reset has priority over all other events.
REQ-026 After reset deassert, a frame starting no earlier than the following cycle SHALL be received normally.

Verification
REQ-027 BIT_TICKS=16, send 0xA5C3 after reset -> single write pulse, data_out=0xA5C3, addr=0x00; next cycle addr=0x01.
REQ-028 Drive serialIn low for 4 cycles then high -> no write, no frame_err, busy returns low, addr=0x00.
REQ-029 Send 0x1234 with stop bit 0 -> frame_err one-cycle pulse, no write, addr unchanged, data_out keeps previous value.
REQ-030 Send 256 back-to-back valid frames -> 256 writes at addr 0x00..0xFF in order; final addr=0x00.
REQ-031 Assert reset at data bit 8 of a frame -> no write, all outputs reset values; next frame 0xFFFF written at addr 0x00.
REQ-032 Back-to-back frames 0x0001, 0x8000 with no idle gap beyond stop bit -> both written, addr 0x00 then 0x01.
